// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: requester handshake, ALU command/result
// channel and the response channel.
//   slave  : the arbiter side (consumes requests and ALU results,
//            drives REQ_READY, ALU_* commands and RSP_*)
//   master : the fabric/ALU side (the mirror image)
interface alu_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int CMD_W = 4,
    parameter int NREQ  = 2
);
    logic [NREQ-1:0]       REQ_VALID;
    logic [NREQ-1:0]       REQ_READY;
    logic [NREQ-1:0]       REQ_MODE;
    logic [NREQ*CMD_W-1:0] REQ_CMD;
    logic [NREQ*WIDTH-1:0] REQ_OPA;
    logic [NREQ*WIDTH-1:0] REQ_OPB;
    logic [NREQ-1:0]       REQ_CIN;

    logic                  ALU_CE;
    logic [1:0]            ALU_INP_VALID;
    logic                  ALU_MODE;
    logic [CMD_W-1:0]      ALU_CMD;
    logic [WIDTH-1:0]      ALU_OPA;
    logic [WIDTH-1:0]      ALU_OPB;
    logic                  ALU_CIN;
    logic [2*WIDTH-1:0]    ALU_RES;
    logic                  ALU_ERR;

    logic [NREQ-1:0]       RSP_VALID;
    logic [2*WIDTH-1:0]    RSP_RES;
    logic                  RSP_ERR;

    modport slave (
        input  REQ_VALID, REQ_MODE, REQ_CMD, REQ_OPA, REQ_OPB, REQ_CIN,
        input  ALU_RES, ALU_ERR,
        output REQ_READY,
        output ALU_CE, ALU_INP_VALID, ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN,
        output RSP_VALID, RSP_RES, RSP_ERR
    );

    modport master (
        output REQ_VALID, REQ_MODE, REQ_CMD, REQ_OPA, REQ_OPB, REQ_CIN,
        output ALU_RES, ALU_ERR,
        input  REQ_READY,
        input  ALU_CE, ALU_INP_VALID, ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN,
        input  RSP_VALID, RSP_RES, RSP_ERR
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NREQ requesters.
// A round-robin arbiter grants one valid request at a time, the winner's
// operands are issued to the ALU for one cycle, the arbiter waits a
// command-dependent latency, captures the result and returns it on a
// one-hot response strobe. One operation is in flight at a time.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : alu_arbiter_if.slave (REQ_*, ALU_*, RSP_* signals)
module alu_arbiter #(
    parameter int WIDTH    = 8,
    parameter int CMD_W    = 4,
    parameter int NREQ     = 2,
    parameter int BASE_LAT = 1,
    parameter int MUL_LAT  = 2
) (
    input  logic         CLK,
    input  logic         RST,
    alu_arbiter_if.slave bus
);
    localparam int PTR_W   = $clog2(NREQ);
    localparam int MAX_LAT = (BASE_LAT > MUL_LAT) ? BASE_LAT : MUL_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q,   ptr_d;
    logic [PTR_W-1:0]     grant_q, grant_d;
    logic                 mode_q,  mode_d;
    logic [CMD_W-1:0]     cmd_q,   cmd_d;
    logic [WIDTH-1:0]     opa_q,   opa_d;
    logic [WIDTH-1:0]     opb_q,   opb_d;
    logic                 cin_q,   cin_d;
    logic [LAT_W-1:0]     cnt_q,   cnt_d;
    logic [2*WIDTH-1:0]   res_q,   res_d;
    logic                 err_q,   err_d;

    // Round-robin winner search
    logic                 win_found;
    logic [PTR_W-1:0]     win_idx;
    int unsigned          cand;

    // Combinational outputs
    logic [NREQ-1:0]      req_ready;
    logic                 alu_ce;
    logic [1:0]           alu_inp_valid;
    logic [NREQ-1:0]      rsp_valid;
    logic                 is_mul;

    // First valid requester at or above the pointer, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!win_found && bus.REQ_VALID[PTR_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end

    assign is_mul = mode_q && ((cmd_q == CMD_W'(9)) || (cmd_q == CMD_W'(10)));

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        mode_d        = mode_q;
        cmd_d         = cmd_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        cin_d         = cin_q;
        cnt_d         = cnt_q;
        res_d         = res_q;
        err_d         = err_q;
        req_ready     = '0;
        alu_ce        = 1'b0;
        alu_inp_valid = 2'b00;
        rsp_valid     = '0;

        unique case (state_q)
            ST_IDLE: begin
                // READY is gated by RST so every output reads 0 during reset
                if (win_found && !RST) begin
                    req_ready[win_idx] = 1'b1;
                    grant_d = win_idx;
                    mode_d  = bus.REQ_MODE[win_idx];
                    cmd_d   = bus.REQ_CMD[int'(win_idx)*CMD_W +: CMD_W];
                    opa_d   = bus.REQ_OPA[int'(win_idx)*WIDTH +: WIDTH];
                    opb_d   = bus.REQ_OPB[int'(win_idx)*WIDTH +: WIDTH];
                    cin_d   = bus.REQ_CIN[win_idx];
                    ptr_d   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_ce        = 1'b1;
                alu_inp_valid = 2'b11;
                cnt_d         = is_mul ? LAT_W'(MUL_LAT) : LAT_W'(BASE_LAT);
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                alu_ce = 1'b1;
                // Only the result present in the last WAIT cycle is taken
                if (cnt_q == LAT_W'(1)) begin
                    res_d   = bus.ALU_RES;
                    err_d   = bus.ALU_ERR;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            mode_q  <= 1'b0;
            cmd_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            mode_q  <= mode_d;
            cmd_q   <= cmd_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign bus.REQ_READY     = req_ready;
    assign bus.ALU_CE        = alu_ce;
    assign bus.ALU_INP_VALID = alu_inp_valid;
    assign bus.ALU_MODE      = mode_q;
    assign bus.ALU_CMD       = cmd_q;
    assign bus.ALU_OPA       = opa_q;
    assign bus.ALU_OPB       = opb_q;
    assign bus.ALU_CIN       = cin_q;
    assign bus.RSP_VALID     = rsp_valid;
    assign bus.RSP_RES       = res_q;
    assign bus.RSP_ERR       = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter (WIDTH=8, CMD_W=4, NREQ=2,
// BASE_LAT=1, MUL_LAT=2). Inputs change 1 time unit after a rising edge;
// outputs are sampled on the falling edge.
module tb_alu_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    alu_arbiter_if #(.WIDTH(8), .CMD_W(4), .NREQ(2)) bus ();

    alu_arbiter #(
        .WIDTH(8), .CMD_W(4), .NREQ(2), .BASE_LAT(1), .MUL_LAT(2)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic mode, input logic [3:0] cmd,
                           input logic [7:0] opa, input logic [7:0] opb, input logic cin);
        bus.REQ_MODE[i]       = mode;
        bus.REQ_CMD[i*4 +: 4] = cmd;
        bus.REQ_OPA[i*8 +: 8] = opa;
        bus.REQ_OPB[i*8 +: 8] = opb;
        bus.REQ_CIN[i]        = cin;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.REQ_VALID = 2'b11;
        bus.REQ_MODE  = '0;
        bus.REQ_CMD   = '0;
        bus.REQ_OPA   = 16'hA5A5;
        bus.REQ_OPB   = 16'h5A5A;
        bus.REQ_CIN   = '0;
        bus.ALU_RES   = 16'hBEEF;
        bus.ALU_ERR   = 1'b1;
        #3;
        checks++; if (bus.REQ_READY !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b want 00", bus.REQ_READY); end
        checks++; if (bus.ALU_CE !== 1'b0) begin errors++; $display("FAIL rst_ce: got %b want 0", bus.ALU_CE); end
        checks++; if (bus.ALU_INP_VALID !== 2'b00) begin errors++; $display("FAIL rst_inp_valid: got %b want 00", bus.ALU_INP_VALID); end
        checks++; if (bus.RSP_VALID !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b want 00", bus.RSP_VALID); end
        checks++; if (bus.RSP_RES !== 16'h0000) begin errors++; $display("FAIL rst_rsp_res: got %h want 0000", bus.RSP_RES); end
        checks++; if (bus.RSP_ERR !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b want 0", bus.RSP_ERR); end
        checks++; if (bus.ALU_OPA !== 8'h00) begin errors++; $display("FAIL rst_opa: got %h want 00", bus.ALU_OPA); end
        next_cycle();
        next_cycle();
        bus.REQ_VALID = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.REQ_READY !== 2'b00) begin errors++; $display("FAIL idle_no_req_ready: got %b want 00", bus.REQ_READY); end
        next_cycle();
    endtask

    // Pointer 0, only req0: result after BASE_LAT=1
    task automatic test_single();
        set_req(0, 1'b1, 4'd0, 8'h05, 8'h03, 1'b0);
        bus.ALU_RES   = 16'h0008;
        bus.ALU_ERR   = 1'b0;
        bus.REQ_VALID = 2'b01;
        @(negedge clk);
        checks++; if (bus.REQ_READY !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", bus.REQ_READY); end
        checks++; if (bus.ALU_INP_VALID !== 2'b00) begin errors++; $display("FAIL single_c0_inp_valid: got %b want 00", bus.ALU_INP_VALID); end
        next_cycle();
        bus.REQ_VALID = 2'b00;
        @(negedge clk);
        checks++; if (bus.ALU_INP_VALID !== 2'b11) begin errors++; $display("FAIL single_issue_valid: got %b want 11", bus.ALU_INP_VALID); end
        checks++; if (bus.ALU_CE !== 1'b1) begin errors++; $display("FAIL single_issue_ce: got %b want 1", bus.ALU_CE); end
        checks++; if (bus.ALU_OPA !== 8'h05 || bus.ALU_OPB !== 8'h03) begin errors++; $display("FAIL single_ops: got %h/%h want 05/03", bus.ALU_OPA, bus.ALU_OPB); end
        checks++; if (bus.ALU_MODE !== 1'b1 || bus.ALU_CMD !== 4'd0) begin errors++; $display("FAIL single_mode_cmd: got %b/%h want 1/0", bus.ALU_MODE, bus.ALU_CMD); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ALU_INP_VALID !== 2'b00) begin errors++; $display("FAIL single_wait_valid: got %b want 00", bus.ALU_INP_VALID); end
        checks++; if (bus.ALU_CE !== 1'b1) begin errors++; $display("FAIL single_wait_ce: got %b want 1", bus.ALU_CE); end
        checks++; if (bus.RSP_VALID !== 2'b00) begin errors++; $display("FAIL single_wait_rsp: got %b want 00", bus.RSP_VALID); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b want 01", bus.RSP_VALID); end
        checks++; if (bus.RSP_RES !== 16'h0008) begin errors++; $display("FAIL single_rsp_res: got %h want 0008", bus.RSP_RES); end
        checks++; if (bus.RSP_ERR !== 1'b0) begin errors++; $display("FAIL single_rsp_err: got %b want 0", bus.RSP_ERR); end
        checks++; if (bus.ALU_CE !== 1'b0) begin errors++; $display("FAIL single_rsp_ce: got %b want 0", bus.ALU_CE); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b00) begin errors++; $display("FAIL single_after_rsp: got %b want 00", bus.RSP_VALID); end
        next_cycle();
    endtask

    // Pointer is 1 here; only req0 valid must be granted without a bubble
    task automatic test_pointer_wrap();
        set_req(0, 1'b0, 4'd1, 8'h11, 8'h22, 1'b0);
        bus.ALU_RES   = 16'h0033;
        bus.REQ_VALID = 2'b01;
        @(negedge clk);
        checks++; if (bus.REQ_READY !== 2'b01) begin errors++; $display("FAIL wrap_ready: got %b want 01", bus.REQ_READY); end
        next_cycle();
        bus.REQ_VALID = 2'b00;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b01) begin errors++; $display("FAIL wrap_rsp_valid: got %b want 01", bus.RSP_VALID); end
        checks++; if (bus.RSP_RES !== 16'h0033) begin errors++; $display("FAIL wrap_rsp_res: got %h want 0033", bus.RSP_RES); end
        next_cycle();
    endtask

    // MODE=1 CMD=9 uses MUL_LAT=2; the first WAIT-cycle result is ignored
    task automatic test_multiply();
        set_req(0, 1'b1, 4'd9, 8'h03, 8'h04, 1'b0);
        bus.ALU_RES   = 16'hDEAD;
        bus.REQ_VALID = 2'b01;
        @(negedge clk);
        checks++; if (bus.REQ_READY !== 2'b01) begin errors++; $display("FAIL mul_ready: got %b want 01", bus.REQ_READY); end
        next_cycle();
        bus.REQ_VALID = 2'b00;
        @(negedge clk);
        checks++; if (bus.ALU_CMD !== 4'd9 || bus.ALU_INP_VALID !== 2'b11) begin errors++; $display("FAIL mul_issue: got cmd %h valid %b want 9/11", bus.ALU_CMD, bus.ALU_INP_VALID); end
        next_cycle();
        bus.ALU_RES = 16'hDEAD;
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b00) begin errors++; $display("FAIL mul_wait1_rsp: got %b want 00", bus.RSP_VALID); end
        next_cycle();
        bus.ALU_RES = 16'h000C;
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b00 || bus.ALU_CE !== 1'b1) begin errors++; $display("FAIL mul_wait2: got rsp %b ce %b want 00/1", bus.RSP_VALID, bus.ALU_CE); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b01) begin errors++; $display("FAIL mul_rsp_valid: got %b want 01", bus.RSP_VALID); end
        checks++; if (bus.RSP_RES !== 16'h000C) begin errors++; $display("FAIL mul_rsp_res: got %h want 000C", bus.RSP_RES); end
        next_cycle();
    endtask

    // Pointer is 1: req1 with an error, then req0 without
    task automatic test_error();
        set_req(1, 1'b0, 4'd1, 8'hF0, 8'h0F, 1'b0);
        bus.ALU_RES   = 16'h0000;
        bus.ALU_ERR   = 1'b1;
        bus.REQ_VALID = 2'b10;
        @(negedge clk);
        checks++; if (bus.REQ_READY !== 2'b10) begin errors++; $display("FAIL err_ready: got %b want 10", bus.REQ_READY); end
        checks++; if (bus.RSP_RES !== 16'h000C) begin errors++; $display("FAIL err_res_hold: got %h want 000C", bus.RSP_RES); end
        next_cycle();
        bus.REQ_VALID = 2'b00;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b10 || bus.RSP_ERR !== 1'b1) begin errors++; $display("FAIL err_rsp: got valid %b err %b want 10/1", bus.RSP_VALID, bus.RSP_ERR); end
        checks++; if (bus.RSP_RES !== 16'h0000) begin errors++; $display("FAIL err_rsp_res: got %h want 0000", bus.RSP_RES); end
        next_cycle();
        set_req(0, 1'b1, 4'd0, 8'h50, 8'h05, 1'b0);
        bus.ALU_RES   = 16'h0055;
        bus.ALU_ERR   = 1'b0;
        bus.REQ_VALID = 2'b01;
        @(negedge clk);
        checks++; if (bus.REQ_READY !== 2'b01) begin errors++; $display("FAIL err2_ready: got %b want 01", bus.REQ_READY); end
        next_cycle();
        bus.REQ_VALID = 2'b00;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b01 || bus.RSP_ERR !== 1'b0) begin errors++; $display("FAIL err2_rsp: got valid %b err %b want 01/0", bus.RSP_VALID, bus.RSP_ERR); end
        checks++; if (bus.RSP_RES !== 16'h0055) begin errors++; $display("FAIL err2_rsp_res: got %h want 0055", bus.RSP_RES); end
        next_cycle();
    endtask

    // Pointer is 1: req1 multiply aborted by reset mid-WAIT, then both
    // requesters held valid alternate 0,1,0,1 every 4 cycles.
    task automatic test_reset_mid_wait_back_to_back();
        logic [1:0] exp;
        set_req(0, 1'b0, 4'd2, 8'h0A, 8'h0B, 1'b0);
        set_req(1, 1'b1, 4'd9, 8'h07, 8'h06, 1'b1);
        bus.ALU_RES   = 16'h1234;
        bus.ALU_ERR   = 1'b0;
        bus.REQ_VALID = 2'b11;
        @(negedge clk);
        checks++; if (bus.REQ_READY !== 2'b10) begin errors++; $display("FAIL abort_ready: got %b want 10", bus.REQ_READY); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ALU_INP_VALID !== 2'b11) begin errors++; $display("FAIL abort_issue: got %b want 11", bus.ALU_INP_VALID); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ALU_CE !== 1'b1) begin errors++; $display("FAIL abort_wait_ce: got %b want 1", bus.ALU_CE); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.ALU_CE !== 1'b0 || bus.ALU_INP_VALID !== 2'b00) begin errors++; $display("FAIL abort_alu_drop: got ce %b valid %b want 0/00", bus.ALU_CE, bus.ALU_INP_VALID); end
        checks++; if (bus.REQ_READY !== 2'b00 || bus.RSP_VALID !== 2'b00) begin errors++; $display("FAIL abort_ready_rsp: got ready %b rsp %b want 00/00", bus.REQ_READY, bus.RSP_VALID); end
        checks++; if (bus.ALU_OPA !== 8'h00) begin errors++; $display("FAIL abort_opa: got %h want 00", bus.ALU_OPA); end
        set_req(1, 1'b0, 4'd1, 8'h07, 8'h06, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.RSP_VALID !== 2'b00) begin errors++; $display("FAIL abort_no_rsp: got %b want 00", bus.RSP_VALID); end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (bus.REQ_READY !== exp) begin errors++; $display("FAIL b2b_grant%0d: got %b want %b", k, bus.REQ_READY, exp); end
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk);
                @(negedge clk);
                checks++; if (bus.REQ_READY !== 2'b00) begin errors++; $display("FAIL b2b_busy%0d_c%0d: got %b want 00", k, c, bus.REQ_READY); end
                checks++; if (bus.RSP_VALID !== ((c == 3) ? exp : 2'b00)) begin errors++; $display("FAIL b2b_rsp%0d_c%0d: got %b want %b", k, c, bus.RSP_VALID, (c == 3) ? exp : 2'b00); end
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.REQ_VALID = 2'b00;
        next_cycle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_pointer_wrap();
        test_multiply();
        test_error();
        test_reset_mid_wait_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
